pixel_fetch_serializer: RTL
===========================

// Module: pixel_fetch_serializer
// PURPOSE
//  Upstream/downstream glue around the two-pixel memory decode stage: generates frame-buffer
//  word addresses, prefetches decoded 48-bit words (two 24-bit RGB pixels) into a small FIFO,
//  and serializes them to the video output one pixel per PIX_REQ. It sits between frame-buffer
//  memory/decoder and the VGA timing/output block, and hides memory read latency.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line (even)
//  V_ACTIVE   480  active lines per frame
//  ADDR_W     18   memory word address width; must hold H_ACTIVE*V_ACTIVE/2-1
//  READ_LAT   1    cycles from MEM_RD to valid MEM_RGB (1..3)
//  DEPTH      4    FIFO depth in 48-bit words (power of 2, >= READ_LAT+2)
// PORTS
//  CLK          in   1       system clock
//  RST          in   1       synchronous reset, active-high
//  FRAME_START  in   1       1-cycle pulse: restart fetch at word 0
//  PIX_REQ      in   1       1-cycle pulse: consume current pixel
//  MEM_RGB      in   48      decoded word; [47:24] = first pixel, [23:0] = second pixel
//  MEM_ADDR     out  ADDR_W  word address of issued read
//  MEM_RD       out  1       read strobe; MEM_RGB valid READ_LAT cycles later
//  PIX_RGB      out  24      current pixel (head word, selected half); 0 when !PIX_VALID
//  PIX_VALID    out  1       a pixel is available at PIX_RGB
//  UNDERRUN     out  1       sticky: PIX_REQ seen while !PIX_VALID; cleared by FRAME_START
//  FRAME_DONE   out  1       1-cycle pulse when the last pixel of the frame is consumed
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, FIFO empty, in-flight pipe cleared, half-select 0.
//  - TOTAL = H_ACTIVE*V_ACTIVE/2 words. Word counter issued, pixel counter consumed.
//  - States: IDLE -> FETCH on FRAME_START; FETCH -> DRAIN when word TOTAL-1 is issued;
//    DRAIN -> IDLE on the last PIX_REQ (FRAME_DONE pulses that cycle's next edge, 1 cycle).
//  - Issue (FETCH only): MEM_RD=1 when fifo_count + in_flight < DEPTH; MEM_ADDR = issued;
//    issued increments same cycle. MEM_ADDR holds last value when MEM_RD=0.
//  - In-flight: READ_LAT-deep valid shift register; on its output bit, MEM_RGB is pushed.
//    Issue limit guarantees no push into a full FIFO, including push+pop in one cycle.
//  - Output: PIX_VALID = fifo non-empty. half=0 -> PIX_RGB=head[47:24], half=1 -> head[23:0].
//    PIX_REQ && PIX_VALID: half toggles; if half was 1, head word popped. Latency from
//    word push to PIX_VALID: 1 cycle (registered count), PIX_RGB combinational from head.
//  - PIX_REQ && !PIX_VALID: UNDERRUN<=1, no counters move (pixel lost, display shows 0).
//  - PIX_REQ in IDLE: ignored except UNDERRUN set.
//  - FRAME_START in any state (incl. mid-frame): FIFO flushed, in-flight pipe cleared (late
//    returns discarded), issued/consumed/half <= 0, UNDERRUN <= 0, state FETCH; first MEM_RD
//    of new frame the following cycle. Simultaneous PIX_REQ is ignored (no underrun).
//  - FRAME_START and RST together: RST wins.
//  - Counters never wrap: issued stops at TOTAL; extra PIX_REQ after FRAME_DONE -> UNDERRUN.
// TESTING (bench: H_ACTIVE=4, V_ACTIVE=2 -> TOTAL=4, READ_LAT=1, DEPTH=4, ideal ROM)
//  1 Reset then idle 10 cycles -> MEM_RD=0, PIX_VALID=0, PIX_RGB=0, UNDERRUN=0, FRAME_DONE=0.
//  2 FRAME_START, ROM word n = {24'hA0000n,24'hB0000n}; wait 8 cycles, PIX_REQ x8 back-to-back
//    -> MEM_ADDR 0,1,2,3 once each; pixels A00000,B00000,...,A00003,B00003; FRAME_DONE once.
//  3 FRAME_START then PIX_REQ every cycle from the 2nd cycle -> UNDERRUN=1 on early requests,
//    lost requests not counted; bench continues until FRAME_DONE without mis-order.
//  4 Mid-frame FRAME_START after 3 pixels, with a read in flight -> next pixel is A00000, no
//    stale word appears, UNDERRUN cleared, addresses restart at 0.
//  5 FRAME_START coincident with PIX_REQ -> request ignored, UNDERRUN stays 0; RST mid-FETCH
//    -> all outputs 0 next cycle, MEM_RD stays 0 until next FRAME_START.
//  6 No PIX_REQ after FRAME_START -> exactly DEPTH reads (addr 0..3) then MEM_RD=0 holds.

Source files
------------

// File: rtl/pixel_fetch_serializer.sv
// Prefetches two-pixel frame-buffer words into a small FIFO and serializes them one
// pixel per request, hiding memory read latency from the video output stage.
module pixel_fetch_serializer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 18,
    parameter int READ_LAT = 1,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    input  logic [47:0]       mem_rgb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [23:0]       pix_rgb,
    output logic              pix_valid,
    output logic              underrun,
    output logic              frame_done
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE / 2;
    localparam int IW    = ADDR_W + 1;
    localparam int PW    = ADDR_W + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam int OW    = PTR_W + 3;
    localparam logic [IW-1:0] TOTAL_W  = IW'(TOTAL);
    localparam logic [PW-1:0] LAST_PIX = PW'(2 * TOTAL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_reg;
    logic [IW-1:0]     issued_reg;
    logic [PW-1:0]     consumed_reg;
    logic              half_reg;
    logic [47:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [READ_LAT-1:0] pipe_reg;
    logic              mem_rd_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              underrun_reg, frame_done_reg;

    logic [OW-1:0] occupancy;
    logic [47:0]   head;
    logic          accept, push, pop, can_issue;

    // Committed slots: stored words, returns in the pipe, and the read strobed this cycle.
    always_comb begin
        occupancy = OW'(count_reg) + OW'(mem_rd_reg);
        for (int i = 0; i < READ_LAT; i++) begin
            occupancy = occupancy + OW'(pipe_reg[i]);
        end
    end

    assign pix_valid = (count_reg != '0);
    assign head      = fifo_mem[rd_ptr_reg];
    assign pix_rgb   = !pix_valid ? 24'h0 : (half_reg ? head[23:0] : head[47:24]);
    assign accept    = pix_req && pix_valid && !frame_start && (state_reg != IDLE);
    assign push      = pipe_reg[READ_LAT-1] && !frame_start;
    assign pop       = accept && half_reg;
    assign can_issue = (state_reg == FETCH) && (issued_reg < TOTAL_W) &&
                       (occupancy < OW'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst || frame_start) pipe_reg[gi] <= 1'b0;
                    else                    pipe_reg[gi] <= mem_rd_reg;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst || frame_start) pipe_reg[gi] <= 1'b0;
                    else                    pipe_reg[gi] <= pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= mem_rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            issued_reg     <= '0;
            consumed_reg   <= '0;
            half_reg       <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            mem_rd_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            underrun_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (frame_start) begin
                // Restart launches word 0 immediately; anything still returning is dropped.
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                consumed_reg <= '0;
                half_reg     <= 1'b0;
                underrun_reg <= 1'b0;
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= '0;
                issued_reg   <= IW'(1);
                if (TOTAL == 1) state_reg <= DRAIN;
                else            state_reg <= FETCH;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                count_reg <= count_reg + CW'(push) - CW'(pop);

                if (accept) begin
                    half_reg     <= ~half_reg;
                    consumed_reg <= consumed_reg + 1'b1;
                    if (consumed_reg == LAST_PIX) begin
                        state_reg      <= IDLE;
                        frame_done_reg <= 1'b1;
                    end
                end else if (pix_req) begin
                    underrun_reg <= 1'b1;
                end

                if (can_issue) begin
                    mem_rd_reg   <= 1'b1;
                    mem_addr_reg <= issued_reg[ADDR_W-1:0];
                    issued_reg   <= issued_reg + 1'b1;
                    if (issued_reg == TOTAL_W - 1'b1) state_reg <= DRAIN;
                end else begin
                    mem_rd_reg <= 1'b0;
                end
            end
        end
    end

    assign mem_rd     = mem_rd_reg;
    assign mem_addr   = mem_addr_reg;
    assign underrun   = underrun_reg;
    assign frame_done = frame_done_reg;
endmodule
